// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte/word data-memory responder for the MEM stage.
// Serves one byte per cycle from a 256x8 big-endian array and stalls the
// pipeline through `busy` while a transfer runs. Includes a byte preload port.
//
// state | meaning
// IDLE  | no transfer; preload port active
// XFER  | moving one byte per cycle at base+k
// DONE  | one-cycle completion; preload active, next request may be accepted
module dmem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        R,
  input  logic        E,
  input  logic        RW,
  input  logic        Size,
  input  logic [7:0]  A,
  input  logic [31:0] DI,
  input  logic        init_we,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_data,
  output logic [31:0] DO,
  output logic        busy,
  output logic        done,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state, state_n;
  logic        accept;
  logic        last;
  logic [1:0]  k;
  logic        rw_q;
  logic        size_q;
  logic        mis_q;
  logic [7:0]  base_q;
  logic [31:0] di_q;
  logic [23:0] asm_q;
  logic [31:0] do_q;
  logic [7:0]  xaddr;
  logic [7:0]  rd_byte;
  logic [7:0]  mem [DEPTH];

  // Preload has priority over a request; requests are taken only outside XFER.
  assign accept  = (state != XFER) && E && !init_we;
  assign last    = !size_q || (k == 2'd3);
  assign xaddr   = base_q + {6'b0, k};
  assign rd_byte = mem[xaddr];

  // Status outputs are decoded from the registered state only.
  assign busy      = (state == XFER);
  assign done      = (state == DONE);
  assign align_err = (state == DONE) && mis_q;
  assign DO        = do_q;

  // State register.
  always_ff @(posedge clk) begin
    if (R) state <= IDLE;
    else   state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = accept ? XFER : IDLE;
      XFER:       if (last) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  // Byte array: no reset, so an aborted write keeps the bytes already stored
  // (including the one whose cycle the reset lands on).
  always_ff @(posedge clk) begin
    if (state == XFER && rw_q)
      mem[xaddr] <= di_q[31:24];
    else if (state != XFER && init_we)
      mem[init_addr] <= init_data;
  end

  // Request latch, byte counter, read assembly and output data register.
  always_ff @(posedge clk) begin
    if (R) begin
      k      <= 2'd0;
      rw_q   <= 1'b0;
      size_q <= 1'b0;
      mis_q  <= 1'b0;
      base_q <= 8'h00;
      di_q   <= 32'h0;
      asm_q  <= 24'h0;
      do_q   <= 32'h0;
    end else if (accept) begin
      k      <= 2'd0;
      rw_q   <= RW;
      size_q <= Size;
      mis_q  <= Size && (A[1:0] != 2'b00);
      base_q <= Size ? {A[7:2], 2'b00} : A;
      // A byte write is staged in the top lane so both sizes drain from [31:24].
      di_q   <= Size ? DI : {DI[7:0], 24'h0};
    end else if (state == XFER) begin
      k    <= k + 2'd1;
      di_q <= {di_q[23:0], 8'h00};
      if (!rw_q) begin
        asm_q <= {asm_q[15:0], rd_byte};
        if (last)
          do_q <= size_q ? {asm_q, rd_byte} : {24'h0, rd_byte};
      end
    end
  end

endmodule
